// File: rtl/v_wb_arbiter.sv
// Three-requester vector writeback arbiter feeding two register-file write ports.
// Define V_WB_ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed rq0 > rq1 > rq2.
module v_wb_arbiter #(
  parameter int unsigned VREG_DW = 256,
  parameter int unsigned VREG_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rq0_valid_i,
  input  logic [VREG_AW-1:0] rq0_addr_i,
  input  logic [VREG_DW-1:0] rq0_data_i,
  output logic               rq0_ready_o,
  input  logic               rq1_valid_i,
  input  logic [VREG_AW-1:0] rq1_addr_i,
  input  logic [VREG_DW-1:0] rq1_data_i,
  output logic               rq1_ready_o,
  input  logic               rq2_valid_i,
  input  logic [VREG_AW-1:0] rq2_addr_i,
  input  logic [VREG_DW-1:0] rq2_data_i,
  output logic               rq2_ready_o,
  output logic               is1_vwb_en_o,
  output logic [VREG_AW-1:0] is1_vwb_addr_o,
  output logic [VREG_DW-1:0] is1_vwb_data_o,
  output logic               is2_vwb_en_o,
  output logic [VREG_AW-1:0] is2_vwb_addr_o,
  output logic [VREG_DW-1:0] is2_vwb_data_o,
  output logic [15:0]        stall_cnt_o
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREQ-1:0]    req_valid;
  logic [VREG_AW-1:0] req_addr [NREQ];
  logic [VREG_DW-1:0] req_data [NREQ];

  logic [NREQ-1:0]    ready_c;
  logic               p1_en, p2_en;
  logic [1:0]         p1_idx, p2_idx;
  logic [VREG_AW-1:0] p1_addr;
  logic [1:0]         scan_idx;
  logic [1:0]         ptr, ptr_nxt;
  logic               stall_c;

  function automatic logic [1:0] wrap_inc(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  assign req_valid   = {rq2_valid_i, rq1_valid_i, rq0_valid_i};
  assign req_addr[0] = rq0_addr_i;
  assign req_addr[1] = rq1_addr_i;
  assign req_addr[2] = rq2_addr_i;
  assign req_data[0] = rq0_data_i;
  assign req_data[1] = rq1_data_i;
  assign req_data[2] = rq2_data_i;

  // Scan from ptr; address 0 is a discard that needs no write port.
  always_comb begin
    ready_c  = '0;
    p1_en    = 1'b0;
    p2_en    = 1'b0;
    p1_idx   = 2'd0;
    p2_idx   = 2'd0;
    p1_addr  = '0;
    scan_idx = ptr;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!rst && req_valid[scan_idx]) begin
        if (req_addr[scan_idx] == '0) begin
          ready_c[scan_idx] = 1'b1;
        end else if (!p1_en) begin
          p1_en             = 1'b1;
          p1_idx            = scan_idx;
          p1_addr           = req_addr[scan_idx];
          ready_c[scan_idx] = 1'b1;
        end else if (!p2_en && (req_addr[scan_idx] != p1_addr)) begin
          p2_en             = 1'b1;
          p2_idx            = scan_idx;
          ready_c[scan_idx] = 1'b1;
        end
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  assign stall_c     = |(req_valid & ~ready_c);
  assign rq0_ready_o = ready_c[0];
  assign rq1_ready_o = ready_c[1];
  assign rq2_ready_o = ready_c[2];

  // Priority pointer follows the last nonzero-address grant when rotating.
  always_comb begin
    ptr_nxt = ptr;
`ifdef V_WB_ARB_ROUND_ROBIN_EN
    if (p2_en) begin
      ptr_nxt = wrap_inc(p2_idx);
    end else if (p1_en) begin
      ptr_nxt = wrap_inc(p1_idx);
    end
`else
    ptr_nxt = 2'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is1_vwb_en_o   <= 1'b0;
      is1_vwb_addr_o <= '0;
      is1_vwb_data_o <= '0;
      is2_vwb_en_o   <= 1'b0;
      is2_vwb_addr_o <= '0;
      is2_vwb_data_o <= '0;
      stall_cnt_o    <= '0;
      ptr            <= 2'd0;
    end else begin
      is1_vwb_en_o <= p1_en;
      is2_vwb_en_o <= p2_en;
      if (p1_en) begin
        is1_vwb_addr_o <= req_addr[p1_idx];
        is1_vwb_data_o <= req_data[p1_idx];
      end
      if (p2_en) begin
        is2_vwb_addr_o <= req_addr[p2_idx];
        is2_vwb_data_o <= req_data[p2_idx];
      end
      if (stall_c && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_v_wb_arbiter.sv
// Directed self-checking bench for v_wb_arbiter (default parameters).
module tb_v_wb_arbiter;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rq0_valid_i, rq1_valid_i, rq2_valid_i;
  logic [AW-1:0] rq0_addr_i, rq1_addr_i, rq2_addr_i;
  logic [DW-1:0] rq0_data_i, rq1_data_i, rq2_data_i;
  logic          rq0_ready_o, rq1_ready_o, rq2_ready_o;
  logic          is1_vwb_en_o, is2_vwb_en_o;
  logic [AW-1:0] is1_vwb_addr_o, is2_vwb_addr_o;
  logic [DW-1:0] is1_vwb_data_o, is2_vwb_data_o;
  logic [15:0]   stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] dv [3];
  logic [DW-1:0] dat_a, dat_b, dat_c;

  v_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .rq0_valid_i(rq0_valid_i), .rq0_addr_i(rq0_addr_i), .rq0_data_i(rq0_data_i), .rq0_ready_o(rq0_ready_o),
    .rq1_valid_i(rq1_valid_i), .rq1_addr_i(rq1_addr_i), .rq1_data_i(rq1_data_i), .rq1_ready_o(rq1_ready_o),
    .rq2_valid_i(rq2_valid_i), .rq2_addr_i(rq2_addr_i), .rq2_data_i(rq2_data_i), .rq2_ready_o(rq2_ready_o),
    .is1_vwb_en_o(is1_vwb_en_o), .is1_vwb_addr_o(is1_vwb_addr_o), .is1_vwb_data_o(is1_vwb_data_o),
    .is2_vwb_en_o(is2_vwb_en_o), .is2_vwb_addr_o(is2_vwb_addr_o), .is2_vwb_data_o(is2_vwb_data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2);
    rq0_valid_i = v[0]; rq1_valid_i = v[1]; rq2_valid_i = v[2];
    rq0_addr_i  = a0;   rq1_addr_i  = a1;   rq2_addr_i  = a2;
    rq0_data_i  = d0;   rq1_data_i  = d1;   rq2_data_i  = d2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rdy();
    return {rq2_ready_o, rq1_ready_o, rq0_ready_o};
  endfunction

  logic [2:0]    exp_rdy [3];
  logic [AW-1:0] exp_a1  [3];
  logic [AW-1:0] exp_a2  [3];

  initial begin
    dat_a = {8{32'hA5A5_0001}};
    dat_b = {8{32'hB6B6_0002}};
    dat_c = {8{32'hC7C7_0003}};
    dv[0] = {8{32'h1111_0000}};
    dv[1] = {8{32'h2222_0000}};
    dv[2] = {8{32'h3333_0000}};

    // Reset with every requester valid: nothing may be accepted.
    rst = 1'b1;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, dat_a, dat_b, dat_c);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 256'(rdy()), 256'(3'b000));
    rst = 1'b0;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    tick();
    check("rst_is1_en", 256'(is1_vwb_en_o), 256'(0));
    check("rst_is1_addr", 256'(is1_vwb_addr_o), 256'(0));
    check("rst_is1_data", is1_vwb_data_o, '0);
    check("rst_is2_en", 256'(is2_vwb_en_o), 256'(0));
    check("rst_is2_data", is2_vwb_data_o, '0);
    check("rst_stall", 256'(stall_cnt_o), 256'(0));

    // Two distinct addresses use both ports.
    set_req(3'b011, 5'd3, 5'd5, 5'd0, dat_a, dat_b, '0);
    #1;
    check("dual_ready", 256'(rdy()), 256'(3'b011));
    tick();
    check("dual_is1_en", 256'(is1_vwb_en_o), 256'(1));
    check("dual_is1_addr", 256'(is1_vwb_addr_o), 256'(3));
    check("dual_is1_data", is1_vwb_data_o, dat_a);
    check("dual_is2_en", 256'(is2_vwb_en_o), 256'(1));
    check("dual_is2_addr", 256'(is2_vwb_addr_o), 256'(5));
    check("dual_is2_data", is2_vwb_data_o, dat_b);
    check("dual_stall", 256'(stall_cnt_o), 256'(0));

    // Same address: second requester must wait a cycle.
    set_req(3'b011, 5'd7, 5'd7, 5'd0, dat_c, dat_a, '0);
    #1;
    check("conf_ready", 256'(rdy()), 256'(3'b001));
    tick();
    check("conf_is1_addr", 256'(is1_vwb_addr_o), 256'(7));
    check("conf_is1_data", is1_vwb_data_o, dat_c);
    check("conf_is2_en", 256'(is2_vwb_en_o), 256'(0));
    check("conf_is2_hold", 256'(is2_vwb_addr_o), 256'(5));
    check("conf_stall", 256'(stall_cnt_o), 256'(1));
    set_req(3'b010, 5'd7, 5'd7, 5'd0, dat_c, dat_a, '0);
    #1;
    check("retry_ready", 256'(rdy()), 256'(3'b010));
    tick();
    check("retry_is1_en", 256'(is1_vwb_en_o), 256'(1));
    check("retry_is1_data", is1_vwb_data_o, dat_a);
    check("retry_is2_en", 256'(is2_vwb_en_o), 256'(0));

    // Address 0 is accepted without occupying a port.
    set_req(3'b110, 5'd0, 5'd0, 5'd9, '0, dat_b, dat_c);
    #1;
    check("zero_ready", 256'(rdy()), 256'(3'b110));
    tick();
    check("zero_is1_en", 256'(is1_vwb_en_o), 256'(1));
    check("zero_is1_addr", 256'(is1_vwb_addr_o), 256'(9));
    check("zero_is2_en", 256'(is2_vwb_en_o), 256'(0));
    check("zero_stall", 256'(stall_cnt_o), 256'(1));

    // Reset while a grant is registered drops it.
    rst = 1'b1;
    #1;
    check("rstg_ready", 256'(rdy()), 256'(3'b000));
    tick();
    check("rstg_is1_en", 256'(is1_vwb_en_o), 256'(0));
    check("rstg_is1_addr", 256'(is1_vwb_addr_o), 256'(0));
    check("rstg_stall", 256'(stall_cnt_o), 256'(0));
    rst = 1'b0;

    // Three valid distinct addresses for three cycles.
`ifdef V_WB_ARB_ROUND_ROBIN_EN
    exp_rdy = '{3'b011, 3'b101, 3'b110};
    exp_a1  = '{5'd1, 5'd3, 5'd2};
    exp_a2  = '{5'd2, 5'd1, 5'd3};
`else
    exp_rdy = '{3'b011, 3'b011, 3'b011};
    exp_a1  = '{5'd1, 5'd1, 5'd1};
    exp_a2  = '{5'd2, 5'd2, 5'd2};
`endif
    set_req(3'b111, 5'd1, 5'd2, 5'd3, dv[0], dv[1], dv[2]);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("tri%0d_ready", c), 256'(rdy()), 256'(exp_rdy[c]));
      tick();
      check($sformatf("tri%0d_is1_addr", c), 256'(is1_vwb_addr_o), 256'(exp_a1[c]));
      check($sformatf("tri%0d_is1_data", c), is1_vwb_data_o, dv[exp_a1[c] - 5'd1]);
      check($sformatf("tri%0d_is2_addr", c), 256'(is2_vwb_addr_o), 256'(exp_a2[c]));
      check($sformatf("tri%0d_is2_en", c), 256'(is2_vwb_en_o), 256'(1));
    end
    check("tri_stall", 256'(stall_cnt_o), 256'(3));

    // Long block: counter saturates at 16'hFFFF.
    set_req(3'b111, 5'd4, 5'd4, 5'd4, dat_a, dat_b, dat_c);
    #1;
    check("sat_rq2_ready", 256'(rq2_ready_o), 256'(0));
    repeat (65531) tick();
    check("sat_pre", 256'(stall_cnt_o), 256'(16'hFFFE));
    tick();
    check("sat_hit", 256'(stall_cnt_o), 256'(16'hFFFF));
    repeat (4466) tick();
    check("sat_hold", 256'(stall_cnt_o), 256'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
